// File: rtl/evict_drain_if.sv
// Record ingress from the last winnertree stage plus the host/DMA egress stream.
interface evict_drain_if;
  localparam int unsigned REC_W = 224;

  logic [REC_W-1:0] Evict_in_key;
  logic             Evict_in_key_wr;
  logic             Evict_out_key_alf;
  logic [REC_W-1:0] Out_data;
  logic             Out_valid;
  logic             Out_ready;

  modport master (
    output Evict_in_key, Evict_in_key_wr, Out_ready,
    input  Evict_out_key_alf, Out_data, Out_valid
  );

  modport slave (
    input  Evict_in_key, Evict_in_key_wr, Out_ready,
    output Evict_out_key_alf, Out_data, Out_valid
  );
endinterface

// File: rtl/evict_drain.sv
// AHeap tail stage: frequency filter, RAM-backed record FIFO with prefetch and
// output registers, almost-full back-pressure and saturating statistics.
module evict_drain #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned ALF_MARGIN = 8
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              Flush_n,
  input  logic [31:0]       Freq_min,
  input  logic              Stat_clr,
  evict_drain_if.slave      bus,
  output logic [31:0]       Acc_cnt,
  output logic [31:0]       Filt_cnt,
  output logic [31:0]       Drop_cnt,
  output logic [ADDR_W:0]   Occupancy
);
  localparam int unsigned REC_W = 224;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned OCC_W = ADDR_W + 1;
  localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] ALF_LVL  = OCC_W'(DEPTH - ALF_MARGIN);

  logic [REC_W-1:0]  mem [DEPTH];
  logic [REC_W-1:0]  ram_q;
  logic [REC_W-1:0]  o_data;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              q_vld;
  logic              o_vld;
  logic              alf;
  logic [OCC_W-1:0]  occ;

  logic              wr_c, filt_c, drop_c, acc_c, pop_c, o_load_c, rd_en_c;
  logic [OCC_W-1:0]  mem_cnt_c, occ_nxt_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  // Classify the incoming record and steer the RAM -> prefetch -> output pipeline.
  always_comb begin
    wr_c      = bus.Evict_in_key_wr & Flush_n;
    filt_c    = wr_c & (bus.Evict_in_key[95:64] < Freq_min);
    drop_c    = wr_c & ~filt_c & (occ == FULL_LVL);
    acc_c     = wr_c & ~filt_c & ~drop_c;
    pop_c     = o_vld & bus.Out_ready;
    o_load_c  = q_vld & (~o_vld | pop_c);
    mem_cnt_c = occ - OCC_W'(q_vld) - OCC_W'(o_vld);
    rd_en_c   = Flush_n & (mem_cnt_c != '0) & (~q_vld | o_load_c);
    occ_nxt_c = Flush_n ? (occ + OCC_W'(acc_c) - OCC_W'(pop_c)) : '0;
  end

  // Simple dual-port storage with a registered read port; no reset on the array.
  always_ff @(posedge Clk) begin
    if (acc_c)   mem[wr_ptr] <= bus.Evict_in_key;
    if (rd_en_c) ram_q       <= mem[rd_ptr];
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_vld  <= 1'b0;
      o_vld  <= 1'b0;
      o_data <= '0;
      occ    <= '0;
      alf    <= 1'b0;
    end else begin
      occ <= occ_nxt_c;
      alf <= (occ_nxt_c >= ALF_LVL);
      if (!Flush_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        q_vld  <= 1'b0;
        o_vld  <= 1'b0;
      end else begin
        if (acc_c)    wr_ptr <= wr_ptr + ADDR_W'(1);
        if (rd_en_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
        if (o_load_c) o_data <= ram_q;
        q_vld <= rd_en_c | (q_vld & ~o_load_c);
        o_vld <= o_load_c | (o_vld & ~pop_c);
      end
    end
  end

  // Statistics: clear wins over any same-cycle event.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      Acc_cnt  <= '0;
      Filt_cnt <= '0;
      Drop_cnt <= '0;
    end else if (Stat_clr) begin
      Acc_cnt  <= '0;
      Filt_cnt <= '0;
      Drop_cnt <= '0;
    end else begin
      Acc_cnt  <= sat_inc(Acc_cnt, acc_c);
      Filt_cnt <= sat_inc(Filt_cnt, filt_c);
      Drop_cnt <= sat_inc(Drop_cnt, drop_c);
    end
  end

  assign bus.Out_data          = o_data;
  assign bus.Out_valid         = o_vld;
  assign bus.Evict_out_key_alf = alf;
  assign Occupancy             = occ;
endmodule

// File: tb/tb_evict_drain.sv
// Bench for evict_drain: directed scenarios plus randomized traffic against a
// timestamped-queue reference model of the filter/FIFO/statistics behaviour.
module tb_evict_drain;
  localparam int unsigned REC_W      = 224;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned DEPTH      = 512;
  localparam int unsigned ALF_MARGIN = 8;
  localparam int unsigned ALF_LVL    = DEPTH - ALF_MARGIN;

  logic              Clk = 1'b0;
  logic              Reset_N;
  logic              Flush_n;
  logic [31:0]       Freq_min;
  logic              Stat_clr;
  logic [31:0]       Acc_cnt, Filt_cnt, Drop_cnt;
  logic [ADDR_W:0]   Occupancy;

  evict_drain_if bus ();

  evict_drain #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .ALF_MARGIN(ALF_MARGIN)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .Flush_n(Flush_n), .Freq_min(Freq_min),
    .Stat_clr(Stat_clr), .bus(bus), .Acc_cnt(Acc_cnt), .Filt_cnt(Filt_cnt),
    .Drop_cnt(Drop_cnt), .Occupancy(Occupancy)
  );

  always #5 Clk = ~Clk;

  // Reference: each stored record carries the edge it was stored on; it is
  // visible at the head once two further edges have passed.
  typedef struct {
    logic [REC_W-1:0] d;
    int unsigned      t;
  } ent_t;

  ent_t        mq[$];
  int unsigned cur = 0;
  logic [31:0] m_acc = '0, m_filt = '0, m_drop = '0;
  logic [31:0] fmin = '0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [REC_W-1:0] mk(input logic [127:0] k, input logic [31:0] f,
                                          input logic [31:0] ts, input logic [31:0] h);
    return {k, f, ts, h};
  endfunction

  function automatic logic [REC_W-1:0] rnd_rec(input logic [31:0] f);
    return {$urandom(), $urandom(), $urandom(), $urandom(), f, $urandom(), $urandom()};
  endfunction

  function automatic logic [31:0] bump(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic bit head_visible();
    return (mq.size() > 0) && (mq[0].t + 2 <= cur);
  endfunction

  task automatic compare_all();
    bit ev;
    ev = head_visible();
    check("out_valid", 256'(bus.Out_valid), 256'(ev));
    if (ev) check("out_data", 256'(bus.Out_data), 256'(mq[0].d));
    check("occupancy", 256'(Occupancy), 256'(mq.size()));
    check("alf", 256'(bus.Evict_out_key_alf), 256'(mq.size() >= int'(ALF_LVL)));
    check("acc_cnt", 256'(Acc_cnt), 256'(m_acc));
    check("filt_cnt", 256'(Filt_cnt), 256'(m_filt));
    check("drop_cnt", 256'(Drop_cnt), 256'(m_drop));
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_valid"}, 256'(bus.Out_valid), 256'(0));
    check({pfx, "_data"}, 256'(bus.Out_data), 256'(0));
    check({pfx, "_alf"}, 256'(bus.Evict_out_key_alf), 256'(0));
    check({pfx, "_occ"}, 256'(Occupancy), 256'(0));
    check({pfx, "_acc"}, 256'(Acc_cnt), 256'(0));
    check({pfx, "_filt"}, 256'(Filt_cnt), 256'(0));
    check({pfx, "_drop"}, 256'(Drop_cnt), 256'(0));
  endtask

  // One clock cycle: drive, advance the model across the edge, then compare.
  task automatic step(input logic wr, input logic [REC_W-1:0] rec, input logic rdy,
                      input logic fl_n, input logic sclr);
    bit          pop;
    int unsigned occ0;
    bit          f_ev, d_ev, a_ev;
    bus.Evict_in_key    = rec;
    bus.Evict_in_key_wr = wr;
    bus.Out_ready       = rdy;
    Flush_n             = fl_n;
    Stat_clr            = sclr;
    Freq_min            = fmin;
    pop  = head_visible() && rdy;
    occ0 = mq.size();
    f_ev = 1'b0; d_ev = 1'b0; a_ev = 1'b0;
    @(posedge Clk);
    cur++;
    if (!fl_n) begin
      mq.delete();
    end else begin
      if (wr) begin
        if (rec[95:64] < fmin)  f_ev = 1'b1;
        else if (occ0 == DEPTH) d_ev = 1'b1;
        else                    a_ev = 1'b1;
      end
      if (pop) void'(mq.pop_front());
      if (a_ev) mq.push_back('{d: rec, t: cur});
    end
    if (sclr) begin
      m_acc = '0; m_filt = '0; m_drop = '0;
    end else begin
      if (a_ev) m_acc  = bump(m_acc);
      if (f_ev) m_filt = bump(m_filt);
      if (d_ev) m_drop = bump(m_drop);
    end
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b1, 1'b0);
  endtask

  initial begin
    int rp;
    int fp;
    Reset_N = 1'b0;
    Flush_n = 1'b1;
    Stat_clr = 1'b0;
    Freq_min = '0;
    bus.Evict_in_key = '0;
    bus.Evict_in_key_wr = 1'b0;
    bus.Out_ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_zero("reset");
    Reset_N = 1'b1;

    // Single record, no filtering.
    fmin = 32'd0;
    step(1'b1, mk(128'h1, 32'd5, 32'h10, 32'hA), 1'b1, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Filter floor: FREQ 9 is filtered, 10 and 11 pass.
    fmin = 32'd10;
    for (int f = 9; f <= 11; f++) step(1'b1, rnd_rec(32'(f)), 1'b1, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Overfill with the consumer stalled, then a write+pop at full.
    fmin = 32'd0;
    for (int i = 1; i <= 600; i++) step(1'b1, rnd_rec(32'(i)), 1'b0, 1'b1, 1'b0);
    step(1'b1, rnd_rec(32'd601), 1'b1, 1'b1, 1'b0);
    idle(520, 1'b1);

    // Second fill and drain exercises pointer wrap.
    for (int i = 0; i < 512; i++) step(1'b1, rnd_rec($urandom()), 1'b0, 1'b1, 1'b0);
    idle(520, 1'b1);

    // Stat clear alongside an accepted write, then flush at occupancy 37.
    step(1'b1, rnd_rec(32'd7), 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 36; i++) step(1'b1, rnd_rec(32'd7), 1'b0, 1'b1, 1'b0);
    step(1'b1, rnd_rec(32'd7), 1'b0, 1'b0, 1'b0);
    idle(4, 1'b1);

    // Randomized traffic with alternating consumer pressure.
    for (int blk = 0; blk < 8; blk++) begin
      rp   = (blk % 2 == 0) ? 1 : 8;
      fmin = 32'($urandom_range(0, 12));
      for (int i = 0; i < ((blk % 2 == 0) ? 700 : 300); i++) begin
        fp = $urandom_range(0, 999);
        step($urandom_range(0, 3) != 0, rnd_rec(32'($urandom_range(0, 15))),
             $urandom_range(0, 9) < rp, fp != 0, $urandom_range(0, 255) == 0);
      end
    end
    idle(10, 1'b1);

    // Asynchronous reset mid-burst while the head is valid.
    fmin = 32'd0;
    for (int i = 0; i < 10; i++) step(1'b1, rnd_rec($urandom()), 1'b0, 1'b1, 1'b0);
    #2;
    Reset_N = 1'b0;
    #1;
    check_zero("midrst");
    mq.delete();
    m_acc = '0; m_filt = '0; m_drop = '0;
    @(posedge Clk);
    cur++;
    #1;
    Reset_N = 1'b1;
    step(1'b1, mk(128'hBEEF, 32'd3, 32'h20, 32'h5), 1'b0, 1'b1, 1'b0);
    idle(4, 1'b0);
    idle(3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
